// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT front end.
// With HANN_WINDOW_EN defined the package also carries the Q1.15 Hann window ROM.
package fft_pkg;

    localparam int LOG2N_DEFAULT    = 8;
    localparam int SAMPLE_W_DEFAULT = 16;
    localparam int ADDR_W_MAX       = 16;

    // Codebase word format: 31:16 real, 15:0 imaginary.
    typedef struct packed {
        logic signed [SAMPLE_W_DEFAULT-1:0] re;
        logic signed [SAMPLE_W_DEFAULT-1:0] im;
    } cword_t;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_PRESENTED
    } bank_state_e;

    // Reverse the low 'width' bits of v; bits above 'width' must be zero.
    function automatic logic [ADDR_W_MAX-1:0] bitrev(input logic [ADDR_W_MAX-1:0] v,
                                                     input int width);
        logic [ADDR_W_MAX-1:0] r;
        r = {<<{v}};
        return r >> (ADDR_W_MAX - width);
    endfunction

`ifdef HANN_WINDOW_EN
    localparam int HANN_N = 1 << LOG2N_DEFAULT;
    typedef logic [SAMPLE_W_DEFAULT-1:0] hann_rom_t [HANN_N];

    // Periodic Hann window; the unity peak saturates to 0x7FFF.
    function automatic hann_rom_t gen_hann_rom();
        hann_rom_t rom;
        real       w;
        int        q;
        for (int n = 0; n < HANN_N; n++) begin
            w = 0.5 * (1.0 - $cos(2.0 * 3.141592653589793 * real'(n) / real'(HANN_N)));
            q = int'(w * 32768.0);
            if (q > 32767) q = 32767;
            rom[n] = q[SAMPLE_W_DEFAULT-1:0];
        end
        return rom;
    endfunction

    localparam hann_rom_t HANN_ROM = gen_hann_rom();
`endif

endpackage

// File: rtl/fft_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port with enable.
module fft_frame_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // NOTE: the storage array has no reset so it can map onto block RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_sample_loader.sv
// Ping-pong frame loader: streams samples into bit-reversed banks and presents full frames to the FFT.
// Optional macro HANN_WINDOW_EN applies a Hann window with one extra write-path register stage.
module fft_sample_loader
    import fft_pkg::*;
#(
    parameter  int LOG2N    = LOG2N_DEFAULT,
    parameter  int SAMPLE_W = SAMPLE_W_DEFAULT,
    localparam int N_POINTS = 2**LOG2N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [SAMPLE_W-1:0]   s_data,
    output logic                  frame_valid,
    output logic                  frame_bank,
    input  logic [LOG2N-1:0]      rd_addr,
    output logic [2*SAMPLE_W-1:0] rd_data,
    input  logic                  frame_done,
    output logic                  overrun
);

    localparam int               WORD_W = 2 * SAMPLE_W;
    localparam logic [LOG2N-1:0] LAST   = LOG2N'(N_POINTS - 1);

    bank_state_e      state_q [2];
    bank_state_e      state_d [2];
    logic [LOG2N-1:0] count_q, count_d;
    logic             wr_bank_q, wr_bank_d;
    logic             last_full_q, last_full_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_bank_q, frame_bank_d;
    logic             run_q, rd_sel_q, overrun_q;

    logic             xfer, frame_release, present, present_bank, full0, full1;
    logic [LOG2N-1:0] wr_addr;
    logic             commit_we, commit_bank, commit_last;
    logic [LOG2N-1:0] commit_addr;
    logic [SAMPLE_W-1:0] commit_sample;

    // run_q keeps s_ready low until the first edge after reset release.
    assign s_ready       = run_q && (state_q[wr_bank_q] == BANK_EMPTY ||
                                     state_q[wr_bank_q] == BANK_FILLING);
    assign xfer          = s_valid && s_ready;
    assign frame_release = frame_done && frame_valid_q;
    assign wr_addr       = LOG2N'(bitrev(ADDR_W_MAX'(count_q), LOG2N));

    assign full0        = (state_q[0] == BANK_FULL);
    assign full1        = (state_q[1] == BANK_FULL);
    assign present      = (state_q[0] != BANK_PRESENTED) && (state_q[1] != BANK_PRESENTED) &&
                          (full0 || full1);
    assign present_bank = (full0 && full1) ? ~last_full_q : full1;

`ifdef HANN_WINDOW_EN
    localparam int PW = SAMPLE_W + 17;
    localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

    logic                       pipe_v_q, pipe_bank_q, pipe_last_q;
    logic [LOG2N-1:0]           pipe_addr_q;
    logic [SAMPLE_W-1:0]        pipe_data_q;
    logic signed [PW-1:0]       product, rounded;
    logic [SAMPLE_W-1:0]        windowed;

    // Coefficient is a non-negative Q1.15 value, so it gets a zero sign bit.
    assign product  = PW'($signed(s_data)) * PW'($signed({1'b0, HANN_ROM[count_q]}));
    assign rounded  = (product + PW'(1 << 14)) >>> 15;
    assign windowed = (rounded > SAT_MAX) ? {1'b0, {(SAMPLE_W-1){1'b1}}} :
                      (rounded < SAT_MIN) ? {1'b1, {(SAMPLE_W-1){1'b0}}} :
                      rounded[SAMPLE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v_q    <= 1'b0;
            pipe_bank_q <= 1'b0;
            pipe_last_q <= 1'b0;
            pipe_addr_q <= '0;
            pipe_data_q <= '0;
        end else begin
            pipe_v_q    <= xfer;
            pipe_bank_q <= wr_bank_q;
            pipe_last_q <= (count_q == LAST);
            pipe_addr_q <= wr_addr;
            pipe_data_q <= windowed;
        end
    end

    assign commit_we     = pipe_v_q;
    assign commit_bank   = pipe_bank_q;
    assign commit_addr   = pipe_addr_q;
    assign commit_sample = pipe_data_q;
    assign commit_last   = pipe_v_q && pipe_last_q;
`else
    assign commit_we     = xfer;
    assign commit_bank   = wr_bank_q;
    assign commit_addr   = wr_addr;
    assign commit_sample = s_data;
    assign commit_last   = xfer && (count_q == LAST);
`endif

    // NOTE: every output of this block is defaulted to its held value first, so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        wr_bank_d     = wr_bank_q;
        last_full_d   = last_full_q;
        frame_valid_d = frame_valid_q;
        frame_bank_d  = frame_bank_q;

        // The fill pointer flips on the last handshake even if the other bank is busy;
        // s_ready then stays low until that bank is released.
        if (xfer) begin
            count_d = count_q + 1'b1;
            if (state_q[wr_bank_q] == BANK_EMPTY) state_d[wr_bank_q] = BANK_FILLING;
            if (count_q == LAST)                  wr_bank_d = ~wr_bank_q;
        end
        if (commit_last) begin
            state_d[commit_bank] = BANK_FULL;
            last_full_d          = commit_bank;
        end
        if (frame_release) begin
            state_d[frame_bank_q] = BANK_EMPTY;
            frame_valid_d         = 1'b0;
        end
        if (present) begin
            state_d[present_bank] = BANK_PRESENTED;
            frame_valid_d         = 1'b1;
            frame_bank_d          = present_bank;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0]    <= BANK_EMPTY;
            state_q[1]    <= BANK_EMPTY;
            count_q       <= '0;
            wr_bank_q     <= 1'b0;
            last_full_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_bank_q  <= 1'b0;
            run_q         <= 1'b0;
            rd_sel_q      <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            wr_bank_q     <= wr_bank_d;
            last_full_q   <= last_full_d;
            frame_valid_q <= frame_valid_d;
            frame_bank_q  <= frame_bank_d;
            run_q         <= 1'b1;
            if (frame_valid_q) rd_sel_q <= frame_bank_q;
            if (s_valid && !s_ready) overrun_q <= 1'b1;
        end
    end

    logic [WORD_W-1:0] ram_rdata [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_ram #(
            .AW (LOG2N),
            .DW (WORD_W)
        ) u_ram (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (commit_we && (commit_bank == 1'(b))),
            .waddr_i (commit_addr),
            .wdata_i ({commit_sample, {SAMPLE_W{1'b0}}}),
            .re_i    (frame_valid_q && (frame_bank_q == 1'(b))),
            .raddr_i (rd_addr),
            .rdata_o (ram_rdata[b])
        );
    end

    assign rd_data     = ram_rdata[rd_sel_q];
    assign frame_valid = frame_valid_q;
    assign frame_bank  = frame_bank_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader: directed frames, a readback table and a randomized run
// checked every cycle against a frame-counting reference model.
module tb_fft_sample_loader;
    import fft_pkg::*;

    localparam int LOG2N = 8;
    localparam int N     = 1 << LOG2N;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             frame_done = 1'b0;
    logic [15:0]      s_data = '0;
    logic [LOG2N-1:0] rd_addr = '0;
    logic             s_ready, frame_valid, frame_bank, overrun;
    logic [31:0]      rd_data;

    int errors = 0;
    int checks = 0;

    fft_sample_loader #(
        .LOG2N    (LOG2N),
        .SAMPLE_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .frame_valid (frame_valid),
        .frame_bank  (frame_bank),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Reference model: frames are numbered in arrival order; frame k lives in bank k%2.
    logic [31:0] m_mem [2][N];
    int          m_filled, m_presented, m_released, m_count;
    bit          m_run, m_fv, m_fb, m_ovr;
    logic [31:0] m_rd;

    function automatic int rev(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++)
            if ((v >> i) & 1) r = r | (1 << (LOG2N - 1 - i));
        return r;
    endfunction

    function automatic bit m_ready();
        return m_run && ((m_filled - m_released) <= 1);
    endfunction

    task automatic model_reset();
        m_filled = 0; m_presented = 0; m_released = 0; m_count = 0;
        m_run = 0; m_fv = 0; m_fb = 0; m_ovr = 0; m_rd = '0;
    endtask

    task automatic model_edge();
        bit rdy, rel, pres;
        rdy  = m_ready();
        rel  = frame_done && m_fv;
        pres = !m_fv && (m_presented < m_filled);
        if (m_fv) m_rd = m_mem[m_fb][rd_addr];
        if (s_valid && !rdy) m_ovr = 1;
        if (s_valid && rdy) begin
            m_mem[m_filled % 2][rev(m_count)] = {s_data, 16'h0000};
            m_count++;
            if (m_count == N) begin
                m_count = 0;
                m_filled++;
            end
        end
        if (rel) begin
            m_released++;
            m_fv = 0;
        end
        if (pres) begin
            m_fb = 1'(m_presented % 2);
            m_fv = 1;
            m_presented++;
        end
        m_run = 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("s_ready",     32'(s_ready),     32'(m_ready()));
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("frame_bank",  32'(frame_bank),  32'(m_fb));
        check("overrun",     32'(overrun),     32'(m_ovr));
        check("rd_data",     rd_data,          m_rd);
    endtask

    // Inputs are already stable here; the model advances exactly as the DUT does at the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_valid = 1'b0; frame_done = 1'b0;
        model_reset();
        #1;
        check("rst_s_ready",     32'(s_ready),     32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_bank",  32'(frame_bank),  32'd0);
        check("rst_rd_data",     rd_data,          32'd0);
        check("rst_overrun",     32'(overrun),     32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ready_after_reset", 32'(s_ready), 32'd1);
    endtask

    task automatic wait_frame(input string name);
        for (int k = 0; k < 8 && frame_valid !== 1'b1; k++) step();
        check(name, 32'(frame_valid), 32'd1);
    endtask

    typedef struct {
        logic [LOG2N-1:0] addr;
        logic [31:0]      exp;
    } rd_vec_t;

    rd_vec_t rd_tab [7];
    cword_t  word;

    initial begin
        // Bank 0 holds sample i (value i) at address bitrev(i).
        rd_tab[0] = '{addr: 8'd1,   exp: 32'h0080_0000};
        rd_tab[1] = '{addr: 8'd3,   exp: 32'h00C0_0000};
        rd_tab[2] = '{addr: 8'd0,   exp: 32'h0000_0000};
        rd_tab[3] = '{addr: 8'd2,   exp: 32'h0040_0000};
        rd_tab[4] = '{addr: 8'd128, exp: 32'h0001_0000};
        rd_tab[5] = '{addr: 8'd255, exp: 32'h00FF_0000};
        rd_tab[6] = '{addr: 8'h0F,  exp: 32'h00F0_0000};

        do_reset();

        // frame_done with no frame presented is ignored.
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        check("idle_done_ready", 32'(s_ready),     32'd1);
        check("idle_done_fv",    32'(frame_valid), 32'd0);

        // First frame: value = index.
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            rd_addr = LOG2N'($urandom);
            step();
        end
        s_valid = 1'b0;
        wait_frame("frame0_valid");
        check("frame0_bank", 32'(frame_bank), 32'd0);

        for (int t = 0; t < 7; t++) begin
            rd_addr = rd_tab[t].addr;
            step();
            check("rd_table", rd_data, rd_tab[t].exp);
        end

        // Final write of bank 1 coincides with frame_done for bank 0.
        for (int i = 0; i < N - 1; i++) begin
            s_valid = 1'b1;
            s_data  = 16'h1000 + 16'(i);
            step();
        end
        s_data     = 16'h10FF;
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        check("simul_ready",   32'(s_ready),     32'd1);
        check("simul_idle_fv", 32'(frame_valid), 32'd0);
        s_data = 16'h2000;
        step();
        s_valid = 1'b0;
        check("simul_fv",   32'(frame_valid), 32'd1);
        check("simul_bank", 32'(frame_bank),  32'd1);
        rd_addr = 8'd0;   step(); check("bank1_addr0",   rd_data, 32'h1000_0000);
        rd_addr = 8'd1;   step(); check("bank1_addr1",   rd_data, 32'h1080_0000);
        rd_addr = 8'd255; step(); check("bank1_addr255", rd_data, 32'h10FF_0000);
        word = rd_data;
        check("imag_zero", 32'(word.im), 32'd0);

        // Two frames with no frame_done: loader stalls, then overruns.
        do_reset();
        s_valid = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            s_data = 16'(i * 3);
            step();
        end
        check("stall_ready", 32'(s_ready), 32'd0);
        check("stall_ovr0",  32'(overrun), 32'd0);
        s_data = 16'hDEAD;
        step();
        s_valid = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        check("release_ready", 32'(s_ready),     32'd1);
        check("release_fv",    32'(frame_valid), 32'd0);
        step();
        check("next_fv",   32'(frame_valid), 32'd1);
        check("next_bank", 32'(frame_bank),  32'd1);
        check("ovr_sticky", 32'(overrun),    32'd1);

        // Reset in the middle of a frame, then a fresh frame.
        s_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_data = 16'h5555;
            step();
        end
        do_reset();
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_data  = 16'h8000 ^ 16'(i * 7);
            step();
        end
        s_valid = 1'b0;
        wait_frame("fresh_valid");
        check("fresh_bank", 32'(frame_bank), 32'd0);
        rd_addr = 8'd0; step(); check("fresh_addr0", rd_data, 32'h8000_0000);
        rd_addr = 8'd1; step(); check("fresh_addr1", rd_data, 32'h8380_0000);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            s_valid    = ($urandom_range(0, 99) < 75);
            s_data     = 16'($urandom);
            rd_addr    = LOG2N'($urandom);
            frame_done = ($urandom_range(0, 99) < 3);
            step();
        end
        s_valid    = 1'b0;
        frame_done = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
